// File: rtl/bram_dual_clear_if.sv
// Access bundle for bram_dual_clear: write port, read port and clear control.
// The master drives requests; the slave (the RAM) returns read data and status.
interface bram_dual_clear_if #(
    parameter int unsigned BITWIDTH = 12,
    parameter int unsigned ADRWIDTH = 5
);
    logic                clr_start;
    logic                wr_en;
    logic [ADRWIDTH-1:0] wr_adr;
    logic [BITWIDTH-1:0] din;
    logic                rd_en;
    logic [ADRWIDTH-1:0] rd_adr;
    logic [BITWIDTH-1:0] dout;
    logic                dout_vld;
    logic                busy;
    logic                clr_done;

    modport master (
        output clr_start, wr_en, wr_adr, din, rd_en, rd_adr,
        input  dout, dout_vld, busy, clr_done
    );

    modport slave (
        input  clr_start, wr_en, wr_adr, din, rd_en, rd_adr,
        output dout, dout_vld, busy, clr_done
    );
endinterface

// File: rtl/bram_dual_clear.sv
// Simple-dual-port block RAM with configurable read latency and read-during-write
// policy, plus a clear engine that writes CLEAR_VALUE to every word on request.
module bram_dual_clear #(
    parameter int unsigned          BITWIDTH     = 12,
    parameter int unsigned          RAMDEPTH     = 32,
    parameter int unsigned          READ_LATENCY = 1,
    parameter int unsigned          RDW_MODE     = 0,
    parameter logic [BITWIDTH-1:0]  CLEAR_VALUE  = '0
) (
    input  logic                i_clk_ram,
    input  logic                i_rst,
    bram_dual_clear_if.slave    io_bus
);

    localparam int unsigned         ADRWIDTH = (RAMDEPTH > 1) ? $clog2(RAMDEPTH) : 1;
    localparam int unsigned         CMPWIDTH = ADRWIDTH + 1;
    localparam logic [CMPWIDTH-1:0] DEPTH_C  = CMPWIDTH'(RAMDEPTH);
    localparam logic [ADRWIDTH-1:0] LAST_ADR = ADRWIDTH'(RAMDEPTH - 1);

    generate
        if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
            $error("bram_dual_clear: READ_LATENCY must be 1 or 2");
        end
        if (RDW_MODE > 1) begin : g_bad_rdw
            $error("bram_dual_clear: RDW_MODE must be 0 or 1");
        end
        if (RAMDEPTH == 0) begin : g_bad_depth
            $error("bram_dual_clear: RAMDEPTH must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADRWIDTH-1:0] r_cnt;
    logic [ADRWIDTH-1:0] w_cnt_nxt;
    logic                r_busy;
    logic                w_busy_nxt;
    logic                r_clr_done;
    logic                w_clr_done_nxt;

    logic                w_we;
    logic [ADRWIDTH-1:0] w_wadr;
    logic [BITWIDTH-1:0] w_wdata;
    logic                w_rd_acc;
    logic [BITWIDTH-1:0] w_rdata;

    logic [BITWIDTH-1:0] r_mem [RAMDEPTH];
    logic [BITWIDTH-1:0] r_dout1;
    logic                r_vld1;

    // A start request takes the cycle: any access issued alongside it is dropped
    assign w_rd_acc = (r_state != S_CLEAR) && !io_bus.clr_start && io_bus.rd_en;

    always_ff @(posedge i_clk_ram or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_clr_done <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_busy     <= w_busy_nxt;
            r_clr_done <= w_clr_done_nxt;
        end
    end

    // Next state plus the shared write-port mux (clear engine or user write)
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_busy_nxt     = r_busy;
        w_clr_done_nxt = 1'b0;
        w_we           = 1'b0;
        w_wadr         = io_bus.wr_adr;
        w_wdata        = io_bus.din;
        case (r_state)
            S_CLEAR: begin
                w_we    = 1'b1;
                w_wadr  = r_cnt;
                w_wdata = CLEAR_VALUE;
                if (r_cnt == LAST_ADR) begin
                    w_state_nxt    = S_DONE;
                    w_busy_nxt     = 1'b0;
                    w_clr_done_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + ADRWIDTH'(1);
                end
            end
            default: begin
                if (io_bus.clr_start) begin
                    w_state_nxt = S_CLEAR;
                    w_cnt_nxt   = '0;
                    w_busy_nxt  = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                    w_we        = io_bus.wr_en && ({1'b0, io_bus.wr_adr} < DEPTH_C);
                end
            end
        endcase
    end

    // Memory array carries no reset so it maps onto block RAM
    always_ff @(posedge i_clk_ram) begin
        if (w_we) begin
            r_mem[w_wadr] <= w_wdata;
        end
    end

    always_comb begin
        w_rdata = '0;
        if ({1'b0, io_bus.rd_adr} < DEPTH_C) begin
            if (RDW_MODE == 1 && w_we && (w_wadr == io_bus.rd_adr)) begin
                w_rdata = io_bus.din;
            end else begin
                w_rdata = r_mem[io_bus.rd_adr];
            end
        end
    end

    // First read stage; data only moves on an accepted read so DOUT holds
    always_ff @(posedge i_clk_ram or posedge i_rst) begin
        if (i_rst) begin
            r_vld1  <= 1'b0;
            r_dout1 <= '0;
        end else begin
            r_vld1 <= w_rd_acc;
            if (w_rd_acc) begin
                r_dout1 <= w_rdata;
            end
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic [BITWIDTH-1:0] r_dout2;
            logic                r_vld2;

            always_ff @(posedge i_clk_ram or posedge i_rst) begin
                if (i_rst) begin
                    r_vld2  <= 1'b0;
                    r_dout2 <= '0;
                end else begin
                    r_vld2 <= r_vld1;
                    if (r_vld1) begin
                        r_dout2 <= r_dout1;
                    end
                end
            end

            assign io_bus.dout     = r_dout2;
            assign io_bus.dout_vld = r_vld2;
        end else begin : g_lat1
            assign io_bus.dout     = r_dout1;
            assign io_bus.dout_vld = r_vld1;
        end
    endgenerate

    assign io_bus.busy     = r_busy;
    assign io_bus.clr_done = r_clr_done;

endmodule

// File: tb/tb_bram_dual_clear.sv
// Bench for bram_dual_clear: instance A (defaults) and instance B (latency 2,
// write-first, depth 20) checked against a shadow memory and a read scoreboard.
module tb_bram_dual_clear;

    localparam int unsigned BW = 12;
    localparam int unsigned AW = 5;

    typedef struct {
        logic [BW-1:0] data;
        int            due;
    } sb_t;

    typedef struct {
        int            d;
        bit            we;
        int            wa;
        logic [BW-1:0] wd;
        bit            re;
        int            ra;
        logic [BW-1:0] exp;
    } vec_t;

    logic clk;
    logic rst_a;
    logic rst_b;
    int   cyc;
    int   checks;
    int   errors;

    sb_t           qa[$];
    sb_t           qb[$];
    logic [BW-1:0] mdl [2][32];
    bit            mbusy [2];
    vec_t          vt [14];

    bram_dual_clear_if #(.BITWIDTH(BW), .ADRWIDTH(AW)) a_bus ();
    bram_dual_clear_if #(.BITWIDTH(BW), .ADRWIDTH(AW)) b_bus ();

    bram_dual_clear #(
        .BITWIDTH(BW), .RAMDEPTH(32), .READ_LATENCY(1), .RDW_MODE(0), .CLEAR_VALUE(12'h000)
    ) u_a (
        .i_clk_ram(clk),
        .i_rst    (rst_a),
        .io_bus   (a_bus)
    );

    bram_dual_clear #(
        .BITWIDTH(BW), .RAMDEPTH(20), .READ_LATENCY(2), .RDW_MODE(1), .CLEAR_VALUE(12'h000)
    ) u_b (
        .i_clk_ram(clk),
        .i_rst    (rst_b),
        .io_bus   (b_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic int qsize(input int d);
        return (d == 0) ? qa.size() : qb.size();
    endfunction

    function automatic sb_t qpop(input int d);
        if (d == 0) return qa.pop_front();
        return qb.pop_front();
    endfunction

    function automatic void qpush(input int d, input sb_t e);
        if (d == 0) qa.push_back(e);
        else        qb.push_back(e);
    endfunction

    function automatic int qdue(input int d);
        return (d == 0) ? qa[0].due : qb[0].due;
    endfunction

    // Compare every DOUT_VLD pulse against the oldest outstanding read
    function automatic void mon(input int d, input logic vld, input logic [BW-1:0] dout);
        sb_t e;
        if (vld) begin
            if (qsize(d) == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_vld dut%0d: got data %0h, expected no valid (cycle %0d)", d, dout, cyc);
            end else begin
                e = qpop(d);
                chk($sformatf("rd_data dut%0d", d), 32'(dout), 32'(e.data));
                chk($sformatf("rd_cycle dut%0d", d), 32'(cyc), 32'(e.due));
            end
        end else if (qsize(d) != 0 && qdue(d) <= cyc) begin
            e = qpop(d);
            checks++;
            errors++;
            $display("FAIL missing_vld dut%0d: got no valid, expected data %0h at cycle %0d", d, e.data, e.due);
        end
    endfunction

    always @(negedge clk) begin
        mon(0, a_bus.dout_vld, a_bus.dout);
        mon(1, b_bus.dout_vld, b_bus.dout);
    end

    task automatic idle_bus();
        a_bus.clr_start = 1'b0; a_bus.wr_en = 1'b0; a_bus.wr_adr = '0; a_bus.din = '0;
        a_bus.rd_en = 1'b0; a_bus.rd_adr = '0;
        b_bus.clr_start = 1'b0; b_bus.wr_en = 1'b0; b_bus.wr_adr = '0; b_bus.din = '0;
        b_bus.rd_en = 1'b0; b_bus.rd_adr = '0;
    endtask

    // One cycle of stimulus on DUT d; the model decides what the read should return
    task automatic drive(input int d, input bit clr, input bit we, input int wa, input logic [BW-1:0] wd,
                         input bit re, input int ra, input bit tab, input logic [BW-1:0] texp);
        bit  acc;
        int  lat;
        int  depth;
        bit  rdw;
        sb_t e;
        @(negedge clk);
        idle_bus();
        if (d == 0) begin
            a_bus.clr_start = clr; a_bus.wr_en = we; a_bus.wr_adr = AW'(wa); a_bus.din = wd;
            a_bus.rd_en = re; a_bus.rd_adr = AW'(ra);
        end else begin
            b_bus.clr_start = clr; b_bus.wr_en = we; b_bus.wr_adr = AW'(wa); b_bus.din = wd;
            b_bus.rd_en = re; b_bus.rd_adr = AW'(ra);
        end
        lat   = (d == 0) ? 1 : 2;
        depth = (d == 0) ? 32 : 20;
        rdw   = (d == 1);
        acc   = !clr && !mbusy[d];
        if (re && acc) begin
            if (tab)                                e.data = texp;
            else if (ra >= depth)                   e.data = '0;
            else if (rdw && we && wa == ra)         e.data = wd;
            else                                    e.data = mdl[d][ra];
            e.due = cyc + lat;
            qpush(d, e);
        end
        if (we && acc && wa < depth) mdl[d][wa] = wd;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 1'b0, 1'b0, 0, '0, 1'b0, 0, 1'b0, '0);
    endtask

    task automatic wr(input int d, input int a, input logic [BW-1:0] v);
        drive(d, 1'b0, 1'b1, a, v, 1'b0, 0, 1'b0, '0);
    endtask

    task automatic rd(input int d, input int a);
        drive(d, 1'b0, 1'b0, 0, '0, 1'b1, a, 1'b0, '0);
    endtask

    initial begin
        int nb;
        int nd;

        vt[0]  = '{0, 1,  5, 12'hABC, 0,  0, 12'h000};
        vt[1]  = '{0, 0,  0, 12'h000, 1,  5, 12'hABC};
        vt[2]  = '{0, 1,  7, 12'h055, 0,  0, 12'h000};
        vt[3]  = '{0, 1,  7, 12'h123, 1,  7, 12'h055};
        vt[4]  = '{0, 0,  0, 12'h000, 1,  7, 12'h123};
        vt[5]  = '{0, 1,  3, 12'h3C3, 1,  5, 12'hABC};
        vt[6]  = '{0, 1, 31, 12'hFFF, 0,  0, 12'h000};
        vt[7]  = '{0, 0,  0, 12'h000, 1, 31, 12'hFFF};
        vt[8]  = '{1, 1,  7, 12'h055, 0,  0, 12'h000};
        vt[9]  = '{1, 1,  7, 12'h123, 1,  7, 12'h123};
        vt[10] = '{1, 1, 25, 12'h0FF, 0,  0, 12'h000};
        vt[11] = '{1, 0,  0, 12'h000, 1, 25, 12'h000};
        vt[12] = '{1, 1, 19, 12'h0AA, 0,  0, 12'h000};
        vt[13] = '{1, 0,  0, 12'h000, 1, 19, 12'h0AA};

        checks = 0;
        errors = 0;
        mbusy[0] = 1'b0;
        mbusy[1] = 1'b0;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 32; i++) mdl[d][i] = '0;
        idle_bus();
        rst_a = 1'b1;
        rst_b = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_dout_a", 32'(a_bus.dout), 0);
        chk("rst_vld_a", 32'(a_bus.dout_vld), 0);
        chk("rst_busy_a", 32'(a_bus.busy), 0);
        chk("rst_done_a", 32'(a_bus.clr_done), 0);
        chk("rst_dout_b", 32'(b_bus.dout), 0);
        chk("rst_vld_b", 32'(b_bus.dout_vld), 0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        idle(2);

        for (int i = 0; i < 14; i++)
            drive(vt[i].d, 1'b0, vt[i].we, vt[i].wa, vt[i].wd, vt[i].re, vt[i].ra, 1'b1, vt[i].exp);
        idle(4);
        chk("hold_dout_a", 32'(a_bus.dout), 32'h0FFF);
        chk("hold_vld_a", 32'(a_bus.dout_vld), 0);

        // Latency-2 back-to-back reads, then out-of-range write/read and full readback
        for (int i = 0; i < 20; i++) wr(1, i, (i < 4) ? BW'(12'h010 + i) : BW'(12'h100 + i));
        for (int i = 0; i < 4; i++) rd(1, i);
        wr(1, 25, 12'h0FF);
        rd(1, 25);
        for (int i = 0; i < 20; i++) rd(1, i);
        idle(4);

        // Full clear with dropped accesses on the start cycle and during BUSY
        for (int i = 0; i < 32; i++) wr(0, i, BW'(12'h200 + i));
        drive(0, 1'b1, 1'b1, 9, 12'h999, 1'b1, 2, 1'b0, '0);
        mbusy[0] = 1'b1;
        nb = 0;
        nd = 0;
        for (int i = 0; i < 32; i++) begin
            drive(0, 1'b0, (i == 3), 4, 12'h777, (i == 5), 6, 1'b0, '0);
            nb += int'(a_bus.busy);
            nd += int'(a_bus.clr_done);
        end
        chk("busy_cycles", 32'(nb), 32);
        chk("done_early", 32'(nd), 0);
        idle(1);
        chk("busy_end", 32'(a_bus.busy), 0);
        chk("clr_done_pulse", 32'(a_bus.clr_done), 1);
        mbusy[0] = 1'b0;
        idle(1);
        chk("clr_done_off", 32'(a_bus.clr_done), 0);
        for (int i = 0; i < 32; i++) mdl[0][i] = '0;
        for (int i = 0; i < 32; i++) rd(0, i);
        idle(2);

        // Reset in the middle of a clear: ten words cleared, the rest kept
        for (int i = 0; i < 32; i++) wr(0, i, BW'(12'h300 + i));
        rd(0, 31);
        idle(2);
        drive(0, 1'b1, 1'b0, 0, '0, 1'b0, 0, 1'b0, '0);
        mbusy[0] = 1'b1;
        idle(10);
        @(negedge clk);
        chk("busy_before_rst", 32'(a_bus.busy), 1);
        rst_a = 1'b1;
        #1;
        chk("rst_mid_busy", 32'(a_bus.busy), 0);
        chk("rst_mid_vld", 32'(a_bus.dout_vld), 0);
        chk("rst_mid_dout", 32'(a_bus.dout), 0);
        chk("rst_mid_done", 32'(a_bus.clr_done), 0);
        @(negedge clk);
        rst_a = 1'b0;
        mbusy[0] = 1'b0;
        nd = 0;
        for (int i = 0; i < 10; i++) begin
            idle(1);
            nd += int'(a_bus.clr_done);
        end
        chk("no_done_after_rst", 32'(nd), 0);
        for (int i = 0; i < 10; i++) mdl[0][i] = '0;
        for (int i = 0; i < 32; i++) rd(0, i);
        idle(5);
        chk("sb_drained", 32'(qsize(0) + qsize(1)), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
